popcount_range_detector: RTL and testbench
==========================================

// Module: popcount_range_detector
// PURPOSE
//   Streaming, parametrised generalisation of the 4-input "2 or 3 of 4 set" detector.
//   Each accepted WIDTH-bit word is flagged when its set-bit count lies in [MIN_ONES, MAX_ONES].
//   Two-stage valid/ready pipeline with backpressure and a saturating match counter.
//   Sits between an input producer and a downstream consumer in the logic-exercise datapath.
// PARAMETERS
//   WIDTH     4          input word width, >= 1
//   MIN_ONES  2          lower bound of the match range, inclusive, 0..WIDTH
//   MAX_ONES  WIDTH-1    upper bound of the match range, inclusive, MIN_ONES..WIDTH
//   CNT_W     16         width of the match counter
// PORTS
//   clk        in   1                 rising-edge clock
//   rst        in   1                 asynchronous active-high reset
//   in_valid   in   1                 input word valid
//   in_ready   out  1                 block can accept a word this cycle
//   in_data    in   WIDTH             input word
//   out_valid  out  1                 result valid
//   out_ready  in   1                 consumer accepts the result
//   out_match  out  1                 1 when popcount is in [MIN_ONES, MAX_ONES]
//   out_ones   out  $clog2(WIDTH+1)   popcount of the word
//   cnt_clr    in   1                 synchronous clear of match_cnt
//   match_cnt  out  CNT_W             number of matching results delivered, saturating
// BEHAVIOUR
//   Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_match=0, out_ones=0,
//     match_cnt=0; in_ready=1 once rst deasserts. An in-flight word is discarded.
//   Handshake: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
//     Once out_valid=1, out_valid/out_match/out_ones hold stable until the output transfer.
//   Stage 1: on input transfer, register popcount(in_data) and set s1_valid.
//   Stage 2: register the compare result (MIN_ONES <= ones <= MAX_ONES) and the ones value.
//     out_valid=s2_valid, and the stage-2 registers drive out_match/out_ones.
//   Advance rules: s2 loads when !s2_valid || out_ready. s1 moves to s2 when s1_valid and s2 loads.
//     in_ready = !s1_valid || s1 moves to s2. in_ready is combinational from out_ready.
//     There is no combinational path from in_* to out_*.
//   Latency: 2 cycles from input transfer to out_valid when there is no backpressure.
//     Throughput is 1 word per cycle while out_ready=1.
//   Full: both stages valid and out_ready=0 -> in_ready=0 and no word is lost or duplicated.
//   Empty: out_valid=0, and out_match/out_ones keep their last values.
//   match_cnt: +1 on each output transfer with out_match=1. It saturates at 2^CNT_W-1 and does not wrap.
//     When cnt_clr=1 in the same cycle as a counted transfer, cnt_clr wins and match_cnt=0.
//   Popcount widths: the sum is computed at $clog2(WIDTH+1) bits, so no overflow at all-ones.
//   Elaboration error if MIN_ONES > MAX_ONES or MAX_ONES > WIDTH.
//   With defaults the function equals the original 4-input circuit: 2 or 3 bits set -> 1.
// TESTING
//   Defaults. Stream 0011, 0111, 1111, 0000, 1000 with out_ready=1 -> at cycles +2..+6:
//     match 1,1,0,0,0; ones 2,3,4,0,1; match_cnt ends at 2.
//   Exhaustive sweep of 0000..1111, one word per cycle -> out_match equals (ones==2 || ones==3);
//     match_cnt ends at 10.
//   Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepted words.
//     out_* stay stable. On release, the words come out in order with no loss or duplication.
//   Random valid/ready toggling, 1000 words -> scoreboard match on order, out_match and out_ones.
//   Saturation: CNT_W=3, 9 matching words -> match_cnt sticks at 7. Assert cnt_clr on a matching
//     transfer -> match_cnt=0.
//   Reset mid-stream with both stages full -> out_valid=0 and match_cnt=0 immediately, asynchronously.
//     The next word appears 2 cycles after acceptance.
//   WIDTH=8, MIN_ONES=MAX_ONES=8: only 8'hFF matches. 8'hFE -> match 0, ones 7.

Source files
------------

// File: rtl/popcount_range_detector.sv
// popcount_range_detector
//   Streaming detector. It flags each accepted WIDTH-bit word whose set-bit count
//   lies in [MIN_ONES, MAX_ONES].
//   Stage 1 registers the popcount of the accepted word. Stage 2 registers the
//   range compare and drives the outputs.
//   Valid/ready flow control runs through both stages. in_ready depends
//   combinationally on out_ready, so the pipeline can sustain one word per cycle.
//   A saturating counter tallies the matching results actually handed downstream.
//   With default parameters the match output behaves exactly like the classic
//   "2 or 3 of 4 inputs set" circuit.

module popcount_range_detector #(
  parameter int WIDTH    = 4,
  parameter int MIN_ONES = 2,
  parameter int MAX_ONES = WIDTH - 1,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_match,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             match_cnt
);

  // The popcount is held at $clog2(WIDTH+1) bits, so an all-ones word cannot overflow it.
  localparam int ONES_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject an empty or out-of-range match window while the design is being elaborated.
  generate
    if (MIN_ONES > MAX_ONES || MAX_ONES > WIDTH) begin : g_bad_range
      $error("popcount_range_detector: need MIN_ONES <= MAX_ONES <= WIDTH");
    end
  endgenerate

  logic              s1_valid;
  logic [ONES_W-1:0] s1_ones;
  logic              s2_valid;
  logic              s2_match;
  logic [ONES_W-1:0] s2_ones;

  logic [ONES_W-1:0] in_ones;
  logic              s1_match;
  logic              s2_load;
  logic              s1_move;
  logic              in_fire;
  logic              out_fire;

  // Stage 2 can take new data when it is empty or its result is leaving this cycle.
  // Stage 1 frees up when it is empty or its word moves on.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_move  = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_move;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  assign out_valid = s2_valid;
  assign out_match = s2_match;
  assign out_ones  = s2_ones;

  // Count the set bits of the incoming word, one bit at a time.
  always_comb begin
    in_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_ones = in_ones + ONES_W'(in_data[i]);
    end
  end

  // Perform the range compare as a signed integer compare, so that MIN_ONES = 0 stays well defined.
  always_comb begin
    s1_match = (int'(s1_ones) >= MIN_ONES) && (int'(s1_ones) <= MAX_ONES);
  end

  // Stage 1: capture the popcount of each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ones  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_ones <= in_ones;
      end
    end
  end

  // Stage 2: capture the compare result.
  // When the pipe drains, the data keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_match <= 1'b0;
      s2_ones  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_match <= s1_match;
        s2_ones  <= s1_ones;
      end
    end
  end

  // Saturating tally of delivered matches. A clear overrides a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (out_fire && s2_match && match_cnt != CNT_MAX) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_popcount_range_detector.sv
// tb_popcount_range_detector
//   Exercises three instances of popcount_range_detector:
//     u_dut  - default parameters.
//     u_sat  - 3-bit counter, used to exercise saturation and clear.
//     u_wide - 8-bit words with an exact match at 8 ones.
//   A queue of accepted words is the reference for the default instance.
//   Expected results are derived from each word with $countones.

module tb_popcount_range_detector;

  logic clk;
  logic rst;

  // Default instance
  logic        in_valid, in_ready, out_valid, out_ready, out_match, cnt_clr;
  logic [3:0]  in_data;
  logic [2:0]  out_ones;
  logic [15:0] match_cnt;

  // Saturation instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_match, b_cnt_clr;
  logic [3:0]  b_in_data;
  logic [2:0]  b_out_ones;
  logic [2:0]  b_match_cnt;

  // Wide exact-match instance
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_match, c_cnt_clr;
  logic [7:0]  c_in_data;
  logic [3:0]  c_out_ones;
  logic [15:0] c_match_cnt;

  int vec_count = 0;
  int err_count = 0;

  logic [3:0] sb[$];
  int         model_cnt;
  logic       seen_valid, seen_ready, seen_match;
  logic [2:0] seen_ones;

  popcount_range_detector u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match), .out_ones(out_ones),
    .cnt_clr(cnt_clr), .match_cnt(match_cnt)
  );

  popcount_range_detector #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_match(b_out_match), .out_ones(b_out_ones),
    .cnt_clr(b_cnt_clr), .match_cnt(b_match_cnt)
  );

  popcount_range_detector #(.WIDTH(8), .MIN_ONES(8), .MAX_ONES(8)) u_wide (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_match(c_out_match), .out_ones(c_out_ones),
    .cnt_clr(c_cnt_clr), .match_cnt(c_match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls
  initial begin
    #2000000;
    $display("[TB] FAIL timeout vectors=%0d miscompares=%0d", vec_count, err_count);
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic inRange4(input logic [3:0] w);
    int n;
    n = $countones(w);
    return (n >= 2) && (n <= 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the default instance.
  // Inputs are driven just after a falling edge and outputs are sampled 1 ns later.
  // The reference model updates at the rising edge.
  // match_cnt is checked at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r, input logic clr);
    logic       in_fire, out_fire;
    logic [3:0] w;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    cnt_clr   = clr;
    #1;
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    seen_valid = out_valid;
    seen_ready = in_ready;
    seen_match = out_match;
    seen_ones  = out_ones;
    checkOutput("in_ready", in_ready, !(sb.size() == 2 && !r));
    if (sb.size() == 2) checkOutput("full_out_valid", out_valid, 1);
    if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("out_valid_when_empty", out_valid, 0);
      end else begin
        w = sb[0];
        checkOutput("out_ones", out_ones, $countones(w));
        checkOutput("out_match", out_match, inRange4(w));
      end
    end
    @(posedge clk);
    if (out_fire && sb.size() > 0) begin
      w = sb.pop_front();
      if (!clr && inRange4(w) && model_cnt < 65535) model_cnt++;
    end
    if (clr) model_cnt = 0;
    if (in_fire) sb.push_back(d);
    @(negedge clk);
    checkOutput("match_cnt", match_cnt, model_cnt);
  endtask

  initial begin
    logic [3:0] stream [5];
    logic [3:0] bp_words [3];
    int acc;
    int cycles;
    logic rv, rr, rc;

    stream[0] = 4'b0011; stream[1] = 4'b0111; stream[2] = 4'b1111;
    stream[3] = 4'b0000; stream[4] = 4'b1000;
    bp_words[0] = 4'b0110; bp_words[1] = 4'b1011; bp_words[2] = 4'b1110;

    rst = 1'b1;
    in_valid = 0; in_data = 0; out_ready = 0; cnt_clr = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_cnt_clr = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 1; c_cnt_clr = 0;
    model_cnt = 0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_match", out_match, 0);
    checkOutput("rst_out_ones", out_ones, 0);
    checkOutput("rst_match_cnt", match_cnt, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);

    // Directed stream: results visible from the third cycle on, one per cycle
    for (int k = 0; k < 7; k++) begin
      if (k < 5) applyStimulus(1, stream[k], 1, 0);
      else       applyStimulus(0, 4'b0000, 1, 0);
      checkOutput("stream_latency_valid", seen_valid, (k >= 2));
    end
    checkOutput("stream_cnt", match_cnt, 2);

    // Exhaustive sweep of every 4-bit word
    applyStimulus(0, 4'b0000, 1, 1);
    for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 1, 0);
    applyStimulus(0, 4'b0000, 1, 0);
    applyStimulus(0, 4'b0000, 1, 0);
    checkOutput("sweep_cnt", match_cnt, 10);

    // Backpressure: two words fill the pipe, then in_ready drops and outputs hold
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, bp_words[acc], 0, 0);
      checkOutput("bp_in_ready", seen_ready, (k < 2));
      if (seen_ready) acc++;
      if (k >= 2) begin
        checkOutput("bp_hold_valid", seen_valid, 1);
        checkOutput("bp_hold_ones", seen_ones, 2);
        checkOutput("bp_hold_match", seen_match, 1);
      end
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 4'b0000, 1, 0);
    checkOutput("bp_drain", sb.size(), 0);

    // Random valid/ready traffic until 1000 words are accepted
    acc = 0;
    cycles = 0;
    while (acc < 1000 && cycles < 20000) begin
      rv = ($urandom_range(0, 99) < 70);
      rr = ($urandom_range(0, 99) < 60);
      rc = ($urandom_range(0, 49) == 0);
      applyStimulus(rv, 4'($urandom_range(0, 15)), rr, rc);
      if (rv && seen_ready) acc++;
      cycles++;
    end
    checkOutput("rand_accepted", acc, 1000);
    for (int k = 0; k < 4; k++) applyStimulus(0, 4'b0000, 1, 0);
    checkOutput("rand_drain", sb.size(), 0);

    // Asynchronous reset with both stages full
    applyStimulus(1, 4'b0011, 1, 0);
    applyStimulus(0, 4'b0000, 1, 0);
    applyStimulus(0, 4'b0000, 1, 0);
    checkOutput("pre_rst_cnt_nonzero", (match_cnt != 0), 1);
    applyStimulus(1, 4'b0101, 0, 0);
    applyStimulus(1, 4'b1001, 0, 0);
    checkOutput("pre_rst_full", sb.size(), 2);
    in_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_match_cnt", match_cnt, 0);
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus((k == 0), 4'b0111, 1, 0);
      checkOutput("post_rst_latency", seen_valid, (k == 2));
    end
    applyStimulus(0, 4'b0000, 1, 0);
    in_valid = 0;
    out_ready = 1;

    // Saturation: 9 matches into a 3-bit counter
    for (int i = 0; i < 9; i++) begin
      b_in_valid = 1;
      b_in_data = 4'b0011;
      @(negedge clk);
    end
    b_in_valid = 0;
    repeat (3) @(negedge clk);
    checkOutput("sat_cnt", b_match_cnt, 7);

    // A clear wins over a counted transfer in the same cycle
    b_in_valid = 1;
    b_in_data = 4'b0101;
    @(negedge clk);
    b_in_valid = 0;
    @(negedge clk);
    b_cnt_clr = 1;
    #1;
    checkOutput("clr_transfer_present", b_out_valid && b_out_match, 1);
    @(negedge clk);
    b_cnt_clr = 0;
    checkOutput("clr_cnt", b_match_cnt, 0);

    // Wide instance: only 8'hFF matches
    c_in_valid = 1;
    c_in_data = 8'hFF;
    @(negedge clk);
    c_in_data = 8'hFE;
    @(negedge clk);
    checkOutput("wide_ff_match", c_out_match, 1);
    checkOutput("wide_ff_ones", c_out_ones, 8);
    c_in_data = 8'h00;
    @(negedge clk);
    checkOutput("wide_fe_match", c_out_match, 0);
    checkOutput("wide_fe_ones", c_out_ones, 7);
    c_in_valid = 0;
    @(negedge clk);
    checkOutput("wide_00_match", c_out_match, 0);
    checkOutput("wide_00_ones", c_out_ones, 0);
    @(negedge clk);
    checkOutput("wide_cnt", c_match_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
